// File: rtl/mem_sram_responder.sv
// Memory-side endpoint of the generic req/gnt memory interface. It fronts a
// single-port SRAM macro and returns fixed-latency, in-order responses.
module mem_sram_responder #(
  parameter int unsigned ADDRESS_SIZE    = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned SRAM_WORDS      = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDRESS_SIZE-1:0]       address_i,
  input  logic [DATA_WIDTH-1:0]         data_wdata_i,
  input  logic                          data_req_i,
  input  logic                          data_we_i,
  input  logic [DATA_WIDTH/8-1:0]       data_be_i,
  output logic                          data_gnt_o,
  output logic                          data_rvalid_o,
  output logic [DATA_WIDTH-1:0]         data_rdata_o,
  output logic                          data_err_o,
  input  logic                          stall_i,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [$clog2(SRAM_WORDS)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]         sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]       sram_be_o,
  input  logic [DATA_WIDTH-1:0]         sram_rdata_i
);

  localparam int unsigned BE_W    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(BE_W);
  localparam int unsigned SRAM_AW = $clog2(SRAM_WORDS);
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING) + 1;

  logic [ADDRESS_SIZE-1:0] word_idx;
  logic                    in_range;
  logic                    rvalid;
  logic [CNT_W-1:0]        out_cnt_q;
  logic [CNT_W-1:0]        out_cnt_d;
  logic [LATENCY-1:0]      valid_q;
  logic [LATENCY-1:0]      read_q;
  logic [LATENCY-1:0]      err_q;
  logic [DATA_WIDTH-1:0]   pipe_rdata;

  // Byte address to word index; anything beyond the SRAM depth is an error.
  assign word_idx = address_i >> OFF_W;
  assign in_range = (word_idx >> SRAM_AW) == '0;

  // Responses are suppressed while in reset so in-flight entries vanish.
  assign rvalid = valid_q[LATENCY-1] & ~rst_i;

  // A retiring response frees its slot for a same-cycle grant.
  always_comb begin
    data_gnt_o = 1'b0;
    if (data_req_i && !stall_i && !rst_i &&
        ((out_cnt_q < CNT_W'(MAX_OUTSTANDING)) || rvalid)) begin
      data_gnt_o = 1'b1;
    end
  end

  assign sram_req_o   = data_gnt_o & in_range;
  assign sram_we_o    = data_we_i;
  assign sram_addr_o  = word_idx[SRAM_AW-1:0];
  assign sram_wdata_o = data_wdata_i;
  assign sram_be_o    = data_be_i;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (data_gnt_o && !rvalid) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!data_gnt_o && rvalid) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end
  end

  // Per-grant response tags travel LATENCY stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q <= '0;
      valid_q   <= '0;
      read_q    <= '0;
      err_q     <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      valid_q[0] <= data_gnt_o;
      read_q[0]  <= ~data_we_i;
      err_q[0]   <= ~in_range;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        read_q[i]  <= read_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  // SRAM data arrives one cycle after the grant and rides the remaining stages.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign pipe_rdata = sram_rdata_i;
    end else begin : g_latn
      logic [DATA_WIDTH-1:0] rdata_q [LATENCY-1];
      always_ff @(posedge clk_i) begin
        if (valid_q[0] && read_q[0]) begin
          rdata_q[0] <= sram_rdata_i;
        end
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          rdata_q[i] <= rdata_q[i-1];
        end
      end
      assign pipe_rdata = rdata_q[LATENCY-2];
    end
  endgenerate

  assign data_rvalid_o = rvalid;
  assign data_err_o    = rvalid & err_q[LATENCY-1];
  assign data_rdata_o  = (rvalid && read_q[LATENCY-1] && !err_q[LATENCY-1]) ?
                         pipe_rdata : '0;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Randomized scoreboard bench for mem_sram_responder: a word-level memory model
// predicts each response at grant time and a monitor checks it on rvalid.
module tb_mem_sram_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic        rst;
  logic [63:0] addr, wdata;
  logic        req, we, stall;
  logic [7:0]  be;
  logic        gnt, rvalid, err;
  logic [63:0] rdata;
  logic        sram_req, sram_we;
  logic [9:0]  sram_addr;
  logic [63:0] sram_wdata, sram_rdata;
  logic [7:0]  sram_be;

  // LATENCY=4 / MAX_OUTSTANDING=2 DUT for throttling
  logic [63:0] addr4, wdata4, rdata4, sram_wdata4, sram_rdata4;
  logic        req4, we4, stall4, gnt4, rvalid4, err4, sram_req4, sram_we4;
  logic [7:0]  be4, sram_be4;
  logic [9:0]  sram_addr4;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int r4_cnt = 0;

  exp_t        exp_q[$];
  logic [63:0] ref_mem [longint];
  logic [63:0] sram_mem [int];

  mem_sram_responder u_dut (
    .clk_i(clk), .rst_i(rst), .address_i(addr), .data_wdata_i(wdata),
    .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_gnt_o(gnt),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
    .stall_i(stall), .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
    .sram_rdata_i(sram_rdata)
  );

  mem_sram_responder #(.LATENCY(4), .MAX_OUTSTANDING(2)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .address_i(addr4), .data_wdata_i(wdata4),
    .data_req_i(req4), .data_we_i(we4), .data_be_i(be4), .data_gnt_o(gnt4),
    .data_rvalid_o(rvalid4), .data_rdata_o(rdata4), .data_err_o(err4),
    .stall_i(stall4), .sram_req_o(sram_req4), .sram_we_o(sram_we4),
    .sram_addr_o(sram_addr4), .sram_wdata_o(sram_wdata4), .sram_be_o(sram_be4),
    .sram_rdata_i(sram_rdata4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro: single port, byte-enabled write, one-cycle read latency
  always @(posedge clk) begin : sram_model
    logic [63:0] w;
    if (sram_req) begin
      w = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 64'h0;
      if (sram_we) begin
        for (int b = 0; b < 8; b++) if (sram_be[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
        sram_mem[int'(sram_addr)] = w;
      end else begin
        sram_rdata <= w;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a word-addressed memory, one predicted response per grant
  function automatic exp_t model(input bit w, input logic [63:0] a,
                                 input logic [63:0] d, input logic [7:0] b);
    exp_t        e;
    logic [63:0] word;
    logic [63:0] m;
    word    = a / 64'd8;
    e.rdata = 64'h0;
    e.err   = 1'b0;
    e.cyc   = cyc + LAT;
    if (word >= 64'd1024) begin
      e.err = 1'b1;
    end else begin
      m = ref_mem.exists(longint'(word)) ? ref_mem[longint'(word)] : 64'h0;
      if (w) begin
        for (int i = 0; i < 8; i++) if (b[i]) m[i*8 +: 8] = d[i*8 +: 8];
        ref_mem[longint'(word)] = m;
      end else begin
        e.rdata = m;
      end
    end
    return e;
  endfunction

  task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] b, input bit rnd_stall, output int waited);
    bit g;
    bit done;
    bit inr;
    done   = 1'b0;
    waited = 0;
    inr    = (a / 64'd8) < 64'd1024;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    while (!done) begin
      if (rnd_stall) stall = ($urandom_range(0, 3) == 0);
      #1;
      g = gnt;
      check("gnt", 64'(g), 64'(!stall));
      check("sram_req", 64'(sram_req), 64'(g && inr));
      if (g) begin
        if (inr) begin
          check("sram_addr", 64'(sram_addr), (a / 64'd8) & 64'h3FF);
          check("sram_we", 64'(sram_we), 64'(w));
        end
        exp_q.push_back(model(w, a, d, b));
      end
      @(negedge clk);
      if (g) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          check("grant_timeout", 64'(waited), 64'(0));
          done = 1'b1;
        end
      end
    end
    req = 1'b0; stall = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: pops the scoreboard whenever a response is presented
  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("err", 64'(err), 64'(e.err));
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      check("idle_rdata", rdata, 64'h0);
      check("idle_err", 64'(err), 64'(0));
    end
    if (rvalid4) r4_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [7:0]  pat_g;
    logic [7:0]  pat_r;
    logic [63:0] a;
    int          r;
    pat_g = 8'b0011_0011;
    pat_r = 8'b0011_0000;
    sram_rdata = '0;
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = '0; stall = 1'b0;
    req4 = 1'b1; we4 = 1'b0; addr4 = 64'h40; wdata4 = '0; be4 = '0; stall4 = 1'b0;
    sram_rdata4 = '0;

    // Reset state with requests pending
    @(negedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_sram_req", 64'(sram_req), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_gnt4", 64'(gnt4), 64'(0));
    @(negedge clk);
    rst = 1'b0; req = 1'b0; req4 = 1'b0;
    #1;
    check("rst_cnt", 64'(u_dut.out_cnt_q), 64'(0));
    @(negedge clk);

    // Directed: full write/read, partial write, out-of-range
    issue(1'b1, 64'h40, 64'h1122334455667788, 8'hFF, 1'b0, w);
    issue(1'b0, 64'h40, 64'h0, 8'h00, 1'b0, w);
    issue(1'b1, 64'h48, 64'h1122334455667788, 8'hFF, 1'b0, w);
    issue(1'b1, 64'h48, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, w);
    issue(1'b0, 64'h48, 64'h0, 8'h00, 1'b0, w);
    issue(1'b1, 64'h50, 64'h5555555555555555, 8'h00, 1'b0, w);
    issue(1'b0, 64'h50, 64'h0, 8'h00, 1'b0, w);
    issue(1'b0, 64'h2000, 64'h0, 8'h00, 1'b0, w);
    issue(1'b1, 64'h2008, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, w);
    drain();

    // Stall held for three cycles, grant when it drops
    req = 1'b1; we = 1'b0; addr = 64'h48; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_gnt", 64'(gnt), 64'(0));
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    check("unstall_gnt", 64'(gnt), 64'(1));
    if (gnt) exp_q.push_back(model(1'b0, 64'h48, 64'h0, 8'h00));
    @(negedge clk);
    req = 1'b0;
    drain();

    // Throttling on the LATENCY=4 / MAX_OUTSTANDING=2 instance
    req4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("l4_gnt", 64'(gnt4), 64'(pat_g[i]));
      check("l4_rvalid", 64'(rvalid4), 64'(pat_r[i]));
      check("l4_outstanding", 64'(u_dut4.out_cnt_q <= 3'd2), 64'(1));
      @(negedge clk);
    end
    req4 = 1'b0;
    repeat (6) @(negedge clk);
    check("l4_resp_count", 64'(r4_cnt), 64'(4));

    // Randomized traffic with random stalls and gaps
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
      else if (r == 8) a = 64'h2000 + 64'($urandom_range(0, 4095));
      else             a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom), 1'b1, w);
    end
    drain();

    // Reset with two responses in flight
    issue(1'b1, 64'h80, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0, w);
    drain();
    issue(1'b0, 64'h80, 64'h0, 8'h00, 1'b0, w);
    issue(1'b0, 64'h40, 64'h0, 8'h00, 1'b0, w);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_cnt", 64'(u_dut.out_cnt_q), 64'(0));
    issue(1'b0, 64'h80, 64'h0, 8'h00, 1'b0, w);
    check("midrst_regrant", 64'(w), 64'(0));
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
